mat_vec_mul_ctrl: RTL and testbench

//  Sequencer for GF(2^8) matrix-vector multiply over N_GF parallel gf_mul lanes.

---
 rtl/mat_vec_mul_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mat_vec_mul_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_vec_mul_ctrl.sv
// GF(2^8) matrix-vector multiply sequencer.
// Streams one matrix word and its matching vector word per cycle, tracks each word
// through the RAM + gf_mul latency with a tag pipeline, XOR-reduces the lane
// products and writes one accumulated byte per matrix row.
module mat_vec_mul_ctrl #(
    parameter int MAT_ROW_SIZE = 8,
    parameter int MAT_COL_SIZE = 8,
    parameter int N_GF         = 8,
    parameter int RD_LAT       = 1,
    parameter int MUL_LAT      = 1,
    localparam int PROC_SIZE   = N_GF * 8,
    localparam int WPR         = MAT_COL_SIZE / N_GF,
    localparam int MAT_WORDS   = MAT_ROW_SIZE * WPR,
    localparam int PIPE        = RD_LAT + MUL_LAT,
    localparam int MAT_AW      = (MAT_WORDS > 1) ? $clog2(MAT_WORDS) : 1,
    localparam int VEC_AW      = (WPR > 1) ? $clog2(WPR) : 1,
    localparam int ROW_AW      = (MAT_ROW_SIZE > 1) ? $clog2(MAT_ROW_SIZE) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_mat_rd_en,
    output logic [MAT_AW-1:0]    o_mat_addr,
    output logic                 o_vec_rd_en,
    output logic [VEC_AW-1:0]    o_vec_addr,
    output logic                 o_mul_start,
    input  logic [PROC_SIZE-1:0] i_mul_out,
    output logic                 o_res_wr_en,
    output logic [ROW_AW-1:0]    o_res_addr,
    output logic [7:0]           o_res
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    typedef struct packed {
        logic              valid;
        logic              first;
        logic              last;
        logic [ROW_AW-1:0] row;
    } tag_t;

    state_t            state, state_nx;
    tag_t              tags [PIPE];
    tag_t              tag_in, tag_out;
    logic              start_q, start_ok;
    logic [MAT_AW-1:0] word_cnt;
    logic [VEC_AW-1:0] col_cnt;
    logic [ROW_AW-1:0] row_cnt;
    logic              last_word, pipe_empty;
    logic [7:0]        lane_xor, acc, acc_nx;
    logic              res_wr_en;
    logic [ROW_AW-1:0] res_addr;
    logic [7:0]        res;

    // Start is edge-qualified so a level held across a whole run cannot retrigger.
    assign start_ok  = i_start & ~start_q;
    assign last_word = (word_cnt == MAT_AW'(MAT_WORDS - 1));
    assign tag_out   = tags[PIPE-1];

    // Previous-cycle copy of i_start for edge qualification.
    always_ff @(posedge i_clk) begin
        if (i_rst) start_q <= 1'b0;
        else       start_q <= i_start;
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic and control outputs.
    always_comb begin
        state_nx    = state;
        o_busy      = (state != IDLE);
        o_done      = (state == DONE);
        o_mat_rd_en = (state == ISSUE);
        o_vec_rd_en = (state == ISSUE);
        case (state)
            IDLE:    if (start_ok) state_nx = ISSUE;
            ISSUE:   if (last_word) state_nx = DRAIN;
            DRAIN:   if (pipe_empty && res_wr_en) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign o_mat_addr = o_mat_rd_en ? word_cnt : '0;
    assign o_vec_addr = o_vec_rd_en ? col_cnt : '0;

    // Word / column / row counters; they hold on the final word instead of wrapping.
    always_ff @(posedge i_clk) begin
        if (i_rst || (state == IDLE && start_ok)) begin
            word_cnt <= '0;
            col_cnt  <= '0;
            row_cnt  <= '0;
        end else if (state == ISSUE && !last_word) begin
            word_cnt <= word_cnt + 1'b1;
            if (col_cnt == VEC_AW'(WPR - 1)) begin
                col_cnt <= '0;
                row_cnt <= row_cnt + 1'b1;
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    // Tag describing the word issued this cycle.
    always_comb begin
        tag_in       = '0;
        tag_in.valid = (state == ISSUE);
        tag_in.first = (col_cnt == '0);
        tag_in.last  = (col_cnt == VEC_AW'(WPR - 1));
        tag_in.row   = row_cnt;
    end

    // Tag shift register spanning RAM read and multiply latency.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < PIPE; i++) tags[i] <= '0;
        end else begin
            tags[0] <= tag_in;
            for (int unsigned i = 1; i < PIPE; i++) tags[i] <= tags[i-1];
        end
    end

    assign o_mul_start = tags[RD_LAT-1].valid;

    // Pipeline occupancy and byte-wide XOR reduction of the lane products.
    always_comb begin
        pipe_empty = 1'b1;
        for (int unsigned i = 0; i < PIPE; i++) begin
            if (tags[i].valid) pipe_empty = 1'b0;
        end
        lane_xor = '0;
        for (int unsigned i = 0; i < N_GF; i++) begin
            lane_xor = lane_xor ^ i_mul_out[i*8 +: 8];
        end
        acc_nx = tag_out.first ? lane_xor : (acc ^ lane_xor);
    end

    // Row accumulator and result write port.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc       <= '0;
            res_wr_en <= 1'b0;
            res_addr  <= '0;
            res       <= '0;
        end else begin
            res_wr_en <= tag_out.valid & tag_out.last;
            if (tag_out.valid) begin
                acc <= acc_nx;
                if (tag_out.last) begin
                    res      <= acc_nx;
                    res_addr <= tag_out.row;
                end
            end
        end
    end

    assign o_res_wr_en = res_wr_en;
    assign o_res_addr  = res_addr;
    assign o_res       = res;

endmodule

// File: tb/tb_mat_vec_mul_ctrl.sv
// Self-checking bench for mat_vec_mul_ctrl: instance A uses default parameters,
// instance B uses 16 columns and a 3-cycle multiplier. RAMs and gf_mul lanes are
// modelled here; expected writes, done pulses and mul_start cycles are queued at
// stimulus time and popped when the DUT produces them.
module tb_mat_vec_mul_ctrl;

    typedef struct {
        logic [1023:0] mat;
        logic [127:0]  vec;
        logic [63:0]   exp;
    } rec_t;

    typedef struct {
        int         cyc;
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic clk, rst;
    int   cyc = 0;
    int   n_vec = 0, n_miss = 0;

    // Instance A signals
    logic        a_start, a_busy, a_done, a_mat_rd_en, a_vec_rd_en, a_mul_start, a_res_wr_en;
    logic [2:0]  a_mat_addr;
    logic [0:0]  a_vec_addr;
    logic [63:0] a_mul_out;
    logic [2:0]  a_res_addr;
    logic [7:0]  a_res;
    // Instance B signals
    logic        b_start, b_busy, b_done, b_mat_rd_en, b_vec_rd_en, b_mul_start, b_res_wr_en;
    logic [3:0]  b_mat_addr;
    logic [0:0]  b_vec_addr;
    logic [63:0] b_mul_out;
    logic [2:0]  b_res_addr;
    logic [7:0]  b_res;

    logic [1023:0] mat_a, mat_b;
    logic [127:0]  vec_a, vec_b;
    logic [63:0]   a_mat_q, a_vec_q, b_mat_q, b_vec_q, b_s0, b_s1;

    wr_t qa[$], qb[$];
    int  qms[$];
    int  a_done_cyc = -1, b_done_cyc = -1;
    int  a_blo = 1, a_bhi = 0, b_blo = 1, b_bhi = 0;

    rec_t ra [5];
    rec_t rb [3];

    mat_vec_mul_ctrl #(.MAT_ROW_SIZE(8), .MAT_COL_SIZE(8), .N_GF(8), .RD_LAT(1), .MUL_LAT(1)) u_a (
        .i_clk(clk), .i_rst(rst), .i_start(a_start), .o_busy(a_busy), .o_done(a_done),
        .o_mat_rd_en(a_mat_rd_en), .o_mat_addr(a_mat_addr), .o_vec_rd_en(a_vec_rd_en),
        .o_vec_addr(a_vec_addr), .o_mul_start(a_mul_start), .i_mul_out(a_mul_out),
        .o_res_wr_en(a_res_wr_en), .o_res_addr(a_res_addr), .o_res(a_res));

    mat_vec_mul_ctrl #(.MAT_ROW_SIZE(8), .MAT_COL_SIZE(16), .N_GF(8), .RD_LAT(1), .MUL_LAT(3)) u_b (
        .i_clk(clk), .i_rst(rst), .i_start(b_start), .o_busy(b_busy), .o_done(b_done),
        .o_mat_rd_en(b_mat_rd_en), .o_mat_addr(b_mat_addr), .o_vec_rd_en(b_vec_rd_en),
        .o_vec_addr(b_vec_addr), .o_mul_start(b_mul_start), .i_mul_out(b_mul_out),
        .o_res_wr_en(b_res_wr_en), .o_res_addr(b_res_addr), .o_res(b_res));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // GF(2^8) multiply, polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [63:0] lanes(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        for (int j = 0; j < 8; j++) r[j*8 +: 8] = gf8(a[j*8 +: 8], b[j*8 +: 8]);
        return r;
    endfunction

    function automatic logic [63:0] ref_res(input logic [1023:0] m, input logic [127:0] v,
                                            input int cols);
        logic [63:0] r;
        logic [7:0]  acc;
        r = '0;
        for (int row = 0; row < 8; row++) begin
            acc = '0;
            for (int c = 0; c < cols; c++) acc = acc ^ gf8(m[(row*cols + c)*8 +: 8], v[c*8 +: 8]);
            r[row*8 +: 8] = acc;
        end
        return r;
    endfunction

    // Operand RAM and gf_mul lane models; idle multiplier outputs carry junk.
    always @(posedge clk) begin
        if (a_mat_rd_en) a_mat_q <= mat_a[int'(a_mat_addr)*64 +: 64];
        if (a_vec_rd_en) a_vec_q <= vec_a[int'(a_vec_addr)*64 +: 64];
        if (b_mat_rd_en) b_mat_q <= mat_b[int'(b_mat_addr)*64 +: 64];
        if (b_vec_rd_en) b_vec_q <= vec_b[int'(b_vec_addr)*64 +: 64];
        a_mul_out <= a_mul_start ? lanes(a_mat_q, a_vec_q) : {$urandom, $urandom};
        b_s0      <= b_mul_start ? lanes(b_mat_q, b_vec_q) : {$urandom, $urandom};
        b_s1      <= b_s0;
        b_mul_out <= b_s1;
    end

    task automatic check(input bit ok, input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_vec++;
        if (!ok) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        wr_t e;
        int  m;
        check(a_busy == (cyc >= a_blo && cyc <= a_bhi), "a_busy", 64'(a_busy),
              64'(cyc >= a_blo && cyc <= a_bhi));
        check(b_busy == (cyc >= b_blo && cyc <= b_bhi), "b_busy", 64'(b_busy),
              64'(cyc >= b_blo && cyc <= b_bhi));
        if (a_res_wr_en === 1'b1) begin
            if (qa.size() == 0) check(1'b0, "a_extra_write", {32'(cyc), 8'(a_res_addr), a_res}, 64'd0);
            else begin
                e = qa.pop_front();
                check({32'(cyc), 8'(a_res_addr), a_res} == {32'(e.cyc), e.addr, e.data}, "a_write",
                      {32'(cyc), 8'(a_res_addr), a_res}, {32'(e.cyc), e.addr, e.data});
            end
        end
        if (b_res_wr_en === 1'b1) begin
            if (qb.size() == 0) check(1'b0, "b_extra_write", {32'(cyc), 8'(b_res_addr), b_res}, 64'd0);
            else begin
                e = qb.pop_front();
                check({32'(cyc), 8'(b_res_addr), b_res} == {32'(e.cyc), e.addr, e.data}, "b_write",
                      {32'(cyc), 8'(b_res_addr), b_res}, {32'(e.cyc), e.addr, e.data});
            end
        end
        if (a_done === 1'b1) begin
            check(cyc == a_done_cyc, "a_done_cycle", 64'(cyc), 64'(a_done_cyc));
            a_done_cyc = -1;
        end
        if (b_done === 1'b1) begin
            check(cyc == b_done_cyc, "b_done_cycle", 64'(cyc), 64'(b_done_cyc));
            b_done_cyc = -1;
        end
        if (b_mul_start === 1'b1) begin
            if (qms.size() == 0) check(1'b0, "b_extra_mul_start", 64'(cyc), 64'd0);
            else begin
                m = qms.pop_front();
                check(cyc == m, "b_mul_start", 64'(cyc), 64'(m));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_a(input string name);
        logic [20:0] v;
        v = {a_busy, a_done, a_mat_rd_en, a_vec_rd_en, a_mul_start, a_res_wr_en,
             a_mat_addr, a_vec_addr, a_res_addr, a_res};
        check(v == '0, name, 64'(v), 64'd0);
    endtask

    task automatic check_idle_b(input string name);
        logic [21:0] v;
        v = {b_busy, b_done, b_mat_rd_en, b_vec_rd_en, b_mul_start, b_res_wr_en,
             b_mat_addr, b_vec_addr, b_res_addr, b_res};
        check(v == '0, name, 64'(v), 64'd0);
    endtask

    // Launch on instance A in the current cycle (cycle 0); returns at cycle t0+tail.
    task automatic run_a(input logic [1023:0] m, input logic [127:0] v, input logic [63:0] exp,
                         input int hold, input int tail);
        int  t0;
        wr_t e;
        mat_a = m;
        vec_a = v;
        t0 = cyc;
        for (int r = 0; r < 8; r++) begin
            e.cyc = t0 + r + 4; e.addr = 8'(r); e.data = exp[r*8 +: 8];
            qa.push_back(e);
        end
        a_done_cyc = t0 + 12;
        a_blo = t0 + 1;
        a_bhi = t0 + 12;
        a_start = 1'b1;
        repeat (hold) step();
        a_start = 1'b0;
        while (cyc < t0 + tail) step();
        check(qa.size() == 0, "a_missing_write", 64'(qa.size()), 64'd0);
        check(a_done_cyc == -1, "a_missing_done", 64'(a_done_cyc), 64'hffffffffffffffff);
    endtask

    task automatic run_b(input logic [1023:0] m, input logic [127:0] v, input logic [63:0] exp);
        int  t0;
        wr_t e;
        mat_b = m;
        vec_b = v;
        t0 = cyc;
        for (int r = 0; r < 8; r++) begin
            e.cyc = t0 + 2*r + 7; e.addr = 8'(r); e.data = exp[r*8 +: 8];
            qb.push_back(e);
        end
        for (int k = 0; k < 16; k++) qms.push_back(t0 + 2 + k);
        b_done_cyc = t0 + 22;
        b_blo = t0 + 1;
        b_bhi = t0 + 22;
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        while (cyc < t0 + 26) step();
        check(qb.size() == 0, "b_missing_write", 64'(qb.size()), 64'd0);
        check(qms.size() == 0, "b_missing_mul_start", 64'(qms.size()), 64'd0);
        check(b_done_cyc == -1, "b_missing_done", 64'(b_done_cyc), 64'hffffffffffffffff);
    endtask

    initial begin
        int  t0;
        wr_t e;

        // Instance A vectors: identity, zero, random x2, all-FF.
        for (int i = 0; i < 5; i++) begin
            for (int b = 0; b < 128; b++) ra[i].mat[b*8 +: 8] = 8'($urandom);
            for (int b = 0; b < 16; b++)  ra[i].vec[b*8 +: 8] = 8'($urandom);
        end
        for (int b = 0; b < 64; b++) ra[0].mat[b*8 +: 8] = ((b / 8) == (b % 8)) ? 8'h01 : 8'h00;
        for (int b = 0; b < 8; b++)  ra[0].vec[b*8 +: 8] = 8'(b + 1);
        ra[0].exp = 64'h0807060504030201;
        ra[1].mat = '0;
        ra[1].exp = '0;
        ra[2].exp = ref_res(ra[2].mat, ra[2].vec, 8);
        ra[3].exp = ref_res(ra[3].mat, ra[3].vec, 8);
        for (int b = 0; b < 64; b++) ra[4].mat[b*8 +: 8] = 8'hff;
        ra[4].exp = ref_res(ra[4].mat, ra[4].vec, 8);

        // Instance B vectors: row0 all 01 with vector all 01 / single byte 53, then random.
        for (int i = 0; i < 3; i++) begin
            for (int b = 0; b < 128; b++) rb[i].mat[b*8 +: 8] = 8'($urandom);
            for (int b = 0; b < 16; b++)  rb[i].vec[b*8 +: 8] = 8'($urandom);
        end
        for (int b = 0; b < 16; b++) begin
            rb[0].mat[b*8 +: 8] = 8'h01;
            rb[0].vec[b*8 +: 8] = 8'h01;
            rb[1].mat[b*8 +: 8] = 8'h01;
        end
        rb[1].vec = '0;
        rb[1].vec[15*8 +: 8] = 8'h53;
        rb[0].exp = ref_res(rb[0].mat, rb[0].vec, 16);
        rb[0].exp[7:0] = 8'h00;
        rb[1].exp = ref_res(rb[1].mat, rb[1].vec, 16);
        rb[1].exp[7:0] = 8'h53;
        rb[2].exp = ref_res(rb[2].mat, rb[2].vec, 16);

        rst = 1'b1;
        a_start = 1'b0;
        b_start = 1'b0;
        mat_a = '0; vec_a = '0; mat_b = '0; vec_b = '0;
        repeat (3) step();
        check_idle_a("a_reset_outputs");
        check_idle_b("b_reset_outputs");
        rst = 1'b0;
        step();
        check_idle_a("a_idle_after_reset");

        for (int i = 0; i < 5; i++) run_a(ra[i].mat, ra[i].vec, ra[i].exp, 1, 16);

        // Start held for 20 cycles: one run only.
        run_a(ra[2].mat, ra[2].vec, ra[2].exp, 20, 26);

        // Restart in the cycle right after done.
        run_a(ra[3].mat, ra[3].vec, ra[3].exp, 1, 13);
        run_a(ra[0].mat, ra[0].vec, ra[0].exp, 1, 16);

        // Reset asserted in cycle 6 of a run.
        mat_a = ra[0].mat;
        vec_a = ra[0].vec;
        t0 = cyc;
        for (int r = 0; r < 8; r++) begin
            e.cyc = t0 + r + 4; e.addr = 8'(r); e.data = ra[0].exp[r*8 +: 8];
            qa.push_back(e);
        end
        a_done_cyc = t0 + 12;
        a_blo = t0 + 1;
        a_bhi = t0 + 12;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        while (cyc < t0 + 6) step();
        rst = 1'b1;
        while (qa.size() > 0 && qa[$].cyc > t0 + 6) void'(qa.pop_back());
        a_done_cyc = -1;
        a_bhi = t0 + 6;
        step();
        rst = 1'b0;
        check_idle_a("a_after_midrun_reset");
        repeat (10) step();
        check(qa.size() == 0, "a_pre_reset_writes", 64'(qa.size()), 64'd0);
        run_a(ra[3].mat, ra[3].vec, ra[3].exp, 1, 16);

        for (int i = 0; i < 3; i++) run_b(rb[i].mat, rb[i].vec, rb[i].exp);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
